audio_pll_ctrl: RTL and testbench
=================================

// Module: audio_pll_ctrl
// PURPOSE
//  Power-up/recovery sequencer for the audio PLL (24.576 MHz ref -> mclk/sclk). Drives the
//  PLL reset, waits for lock with timeout and bounded retries, requires a lock-stable settle
//  window, then releases the audio-domain reset. Re-sequences on loss of lock.
//  Runs on the free-running reference oscillator so it keeps running while the PLL is held in reset.
// PARAMETERS
//  RST_CYCLES     16     cycles pll_areset held high per attempt (>=2)
//  LOCK_TIMEOUT   24576  cycles to wait for lock per attempt (1 ms @ 24.576 MHz)
//  SETTLE_CYCLES  256    consecutive synced-lock cycles required before RUN
//  MAX_RETRY      3      failed attempts tolerated; the next failure enters FAULT
//  CNT_W          16     shared timer width; must hold max(all three cycle counts)
// PORTS
//  ref_audio    in   1  reference clock, 24.576 MHz oscillator
//  reset        in   1  synchronous, active-high reset
//  enable       in   1  sequencer enable (level); low forces IDLE
//  pll_locked   in   1  PLL lock, asynchronous; 2-flop synchronised internally -> lock_s
//  pll_areset   out  1  PLL reset, active-high
//  audio_rst_n  out  1  audio-domain reset, active-low; high only in RUN
//  ready        out  1  clocks valid (state==RUN)
//  fault        out  1  retries exhausted (state==FAULT)
//  retry_cnt    out  2  failed attempts in the current bring-up
//  loss_cnt     out  8  lock losses while in RUN; saturates at 255
//  state        out  3  IDLE=0 RESET=1 WAIT_LOCK=2 SETTLE=3 RUN=4 FAULT=5
// BEHAVIOUR
//  - All outputs are registered or decoded from the state register. No combinational input->output path.
//  - On reset: state=IDLE, pll_areset=1, audio_rst_n=0, ready=0, fault=0.
//    retry_cnt=0, loss_cnt=0, timer=0, sync flops=0.
//  - enable==0 in any state -> IDLE next cycle. This has priority over every other transition.
//  - IDLE: pll_areset=1. enable==1 -> RESET; clear retry_cnt and timer.
//  - RESET: pll_areset=1; timer counts 0..RST_CYCLES-1, then -> WAIT_LOCK, timer=0.
//  - WAIT_LOCK: pll_areset=0.
//    - lock_s==1 -> SETTLE, timer=0.
//    - Else, when timer==LOCK_TIMEOUT-1, the attempt fails.
//  - SETTLE: pll_areset=0.
//    - lock_s==0 fails the attempt.
//    - Else, when timer==SETTLE_CYCLES-1 -> RUN.
//  - Attempt failure:
//    - If retry_cnt==MAX_RETRY -> FAULT.
//    - Else retry_cnt+1 and -> RESET, timer=0.
//    - Timeout and lock loss in the same cycle counts as one failure.
//  - RUN: pll_areset=0, audio_rst_n=1, ready=1; retry_cnt cleared on entry.
//    lock_s==0 -> RESET, loss_cnt+1 (saturating), retry_cnt unchanged (0).
//  - FAULT: pll_areset=1, fault=1. Exits only via enable==0 (-> IDLE) or reset.
//  - pll_areset and audio_rst_n are both driven from state, so they change together with the
//    state register (same edge). audio_rst_n drops the cycle RUN is left.
//  - Lock latency: a pll_locked rise reaches lock_s 2 edges later. SETTLE is entered on the 3rd edge.
//    Minimum from enable rise to ready = 1 + RST_CYCLES + 3 + SETTLE_CYCLES edges.
//  - Timer holds 0 in IDLE/RUN/FAULT. It never wraps: every counting state exits at its terminal count.
//  - loss_cnt is cleared only by reset (not by enable), for field diagnostics.
// TESTING  (bench params: RST_CYCLES=4 LOCK_TIMEOUT=20 SETTLE_CYCLES=8 MAX_RETRY=3)
//  1. Clean bring-up: enable=1, pll_locked rises 2 cycles after pll_areset falls.
//     -> ready=1 exactly at the cycle predicted by the latency formula; retry_cnt=0.
//  2. Lock never arrives, enable=1.
//     -> 4 RESET pulses of 4 cycles each, each followed by a 20-cycle wait.
//     -> retry_cnt 0,1,2,3, then FAULT with fault=1, pll_areset=1.
//     -> enable=0 -> IDLE, fault=0.
//  3. Lock glitches low 1 cycle (>=2 sync cycles) in SETTLE.
//     -> RESET, retry_cnt=1. A stable second attempt reaches RUN with retry_cnt=0.
//  4. In RUN, drop pll_locked. -> 2 cycles later state=RESET, audio_rst_n=0, ready=0, loss_cnt=1.
//     Repeat 300x -> loss_cnt=255.
//  5. reset asserted mid-WAIT_LOCK, and enable dropped mid-SETTLE.
//     -> next edge: reset values / IDLE with pll_areset=1. loss_cnt is kept on the enable drop.

Source files
------------

// File: rtl/audio_pll_ctrl.sv
// Audio PLL power-up/recovery sequencer: PLL reset, lock wait with timeout/retries, settle, RUN.
// Latency: outputs decode the state register; pll_locked reaches the FSM after a 2-flop synchroniser.
// Backpressure: none; level-sensitive enable, loss of lock re-sequences from RESET.
//
// Ports:
//   ref_audio   free-running reference clock (keeps running while the PLL is held in reset)
//   reset       synchronous active-high reset
//   enable      sequencer enable; low forces IDLE from any state
//   pll_locked  asynchronous PLL lock indication
//   pll_areset  PLL reset, high in IDLE/RESET/FAULT
//   audio_rst_n audio-domain reset, released only in RUN
//   ready       high in RUN
//   fault       high in FAULT (retries exhausted)
//   retry_cnt   failed attempts in the current bring-up
//   loss_cnt    saturating count of lock losses seen in RUN
//   state       IDLE=0 RESET=1 WAIT_LOCK=2 SETTLE=3 RUN=4 FAULT=5
module audio_pll_ctrl #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 24576,
    parameter int SETTLE_CYCLES = 256,
    parameter int MAX_RETRY     = 3,
    parameter int CNT_W         = 16
) (
    input  logic       ref_audio,
    input  logic       reset,
    input  logic       enable,
    input  logic       pll_locked,
    output logic       pll_areset,
    output logic       audio_rst_n,
    output logic       ready,
    output logic       fault,
    output logic [1:0] retry_cnt,
    output logic [7:0] loss_cnt,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RESET  = 3'd1,
        S_WAIT   = 3'd2,
        S_SETTLE = 3'd3,
        S_RUN    = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [1:0]       RETRY_MAX   = 2'(MAX_RETRY);

    state_t           st;
    logic [CNT_W-1:0] timer;
    logic             lock_m;
    logic             lock_s;
    logic             attempt_fail;

    // A timeout and a lock drop in the same cycle collapse into one failure.
    always_comb begin
        attempt_fail = 1'b0;
        if (st == S_WAIT && !lock_s && timer == LOCK_LAST)
            attempt_fail = 1'b1;
        if (st == S_SETTLE && !lock_s)
            attempt_fail = 1'b1;
    end

    always_ff @(posedge ref_audio) begin
        if (reset) begin
            st        <= S_IDLE;
            timer     <= '0;
            lock_m    <= 1'b0;
            lock_s    <= 1'b0;
            retry_cnt <= 2'd0;
            loss_cnt  <= 8'd0;
        end else begin
            lock_m <= pll_locked;
            lock_s <= lock_m;
            if (!enable) begin
                st    <= S_IDLE;
                timer <= '0;
            end else if (attempt_fail) begin
                timer <= '0;
                if (retry_cnt == RETRY_MAX) begin
                    st <= S_FAULT;
                end else begin
                    st        <= S_RESET;
                    retry_cnt <= retry_cnt + 2'd1;
                end
            end else begin
                case (st)
                    S_IDLE: begin
                        st        <= S_RESET;
                        timer     <= '0;
                        retry_cnt <= 2'd0;
                    end
                    S_RESET: begin
                        if (timer == RST_LAST) begin
                            st    <= S_WAIT;
                            timer <= '0;
                        end else begin
                            timer <= timer + CNT_W'(1);
                        end
                    end
                    S_WAIT: begin
                        if (lock_s) begin
                            st    <= S_SETTLE;
                            timer <= '0;
                        end else begin
                            timer <= timer + CNT_W'(1);
                        end
                    end
                    S_SETTLE: begin
                        // lock_s is known high here; a low lock_s was a failure above.
                        if (timer == SETTLE_LAST) begin
                            st        <= S_RUN;
                            timer     <= '0;
                            retry_cnt <= 2'd0;
                        end else begin
                            timer <= timer + CNT_W'(1);
                        end
                    end
                    S_RUN: begin
                        timer <= '0;
                        if (!lock_s) begin
                            st <= S_RESET;
                            if (loss_cnt != 8'hFF)
                                loss_cnt <= loss_cnt + 8'd1;
                        end
                    end
                    S_FAULT: begin
                        timer <= '0;
                    end
                    default: begin
                        st    <= S_IDLE;
                        timer <= '0;
                    end
                endcase
            end
        end
    end

    // Both resets decode the state register, so they move on the same edge as the state.
    assign state       = st;
    assign pll_areset  = (st == S_IDLE) || (st == S_RESET) || (st == S_FAULT);
    assign audio_rst_n = (st == S_RUN);
    assign ready       = (st == S_RUN);
    assign fault       = (st == S_FAULT);

endmodule

// File: tb/tb_audio_pll_ctrl.sv
// Bench for audio_pll_ctrl: directed vector table, hand sequences, randomized run vs reference model.
// Latency: one check set per clock, sampled 1 time unit after the rising edge.
// Backpressure: none.
module tb_audio_pll_ctrl;

    localparam int RST_C    = 4;
    localparam int TIMEOUT  = 20;
    localparam int SETTLE_C = 8;
    localparam int MAXR     = 3;

    localparam int P_IDLE = 0, P_RESET = 1, P_WAIT = 2, P_SETTLE = 3, P_RUN = 4, P_FAULT = 5;

    logic       ref_audio = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       pll_locked = 1'b0;
    logic       pll_areset;
    logic       audio_rst_n;
    logic       ready;
    logic       fault;
    logic [1:0] retry_cnt;
    logic [7:0] loss_cnt;
    logic [2:0] state;

    audio_pll_ctrl #(
        .RST_CYCLES   (RST_C),
        .LOCK_TIMEOUT (TIMEOUT),
        .SETTLE_CYCLES(SETTLE_C),
        .MAX_RETRY    (MAXR),
        .CNT_W        (16)
    ) dut (
        .ref_audio  (ref_audio),
        .reset      (reset),
        .enable     (enable),
        .pll_locked (pll_locked),
        .pll_areset (pll_areset),
        .audio_rst_n(audio_rst_n),
        .ready      (ready),
        .fault      (fault),
        .retry_cnt  (retry_cnt),
        .loss_cnt   (loss_cnt),
        .state      (state)
    );

    always #5 ref_audio = ~ref_audio;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: phase plus "cycles left" in the current timed phase,
    // and the lock synchroniser as a two-deep delay line.
    int m_phase, m_left, m_retry, m_loss;
    bit m_pipe[2];
    bit m_valid = 1'b0;

    task automatic m_fail();
        if (m_retry == MAXR) begin
            m_phase = P_FAULT;
        end else begin
            m_retry++;
            m_phase = P_RESET;
            m_left  = RST_C - 1;
        end
    endtask

    task automatic model_step(input bit r, input bit e, input bit l);
        bit ls;
        if (r) begin
            m_phase = P_IDLE; m_left = 0; m_retry = 0; m_loss = 0;
            m_pipe[0] = 0; m_pipe[1] = 0;
            m_valid = 1'b1;
            return;
        end
        ls = m_pipe[1];
        m_pipe[1] = m_pipe[0];
        m_pipe[0] = l;
        if (!e) begin
            m_phase = P_IDLE;
            return;
        end
        case (m_phase)
            P_IDLE: begin m_phase = P_RESET; m_left = RST_C - 1; m_retry = 0; end
            P_RESET: begin
                if (m_left == 0) begin m_phase = P_WAIT; m_left = TIMEOUT - 1; end
                else m_left--;
            end
            P_WAIT: begin
                if (ls) begin m_phase = P_SETTLE; m_left = SETTLE_C - 1; end
                else if (m_left == 0) m_fail();
                else m_left--;
            end
            P_SETTLE: begin
                if (!ls) m_fail();
                else if (m_left == 0) begin m_phase = P_RUN; m_retry = 0; end
                else m_left--;
            end
            P_RUN: begin
                if (!ls) begin
                    m_phase = P_RESET; m_left = RST_C - 1;
                    m_loss  = (m_loss < 255) ? m_loss + 1 : 255;
                end
            end
            default: ;
        endcase
    endtask

    task automatic model_check();
        int exp_flags;
        if (!m_valid) return;
        exp_flags = {(m_phase == P_IDLE || m_phase == P_RESET || m_phase == P_FAULT),
                     (m_phase == P_RUN), (m_phase == P_RUN), (m_phase == P_FAULT)};
        chk("model_state", int'(state), m_phase);
        chk("model_flags{areset,rst_n,ready,fault}",
            int'({pll_areset, audio_rst_n, ready, fault}), exp_flags);
        chk("model_retry", int'(retry_cnt), m_retry);
        chk("model_loss", int'(loss_cnt), m_loss);
    endtask

    task automatic step(input bit r, input bit e, input bit l);
        reset = r; enable = e; pll_locked = l;
        @(posedge ref_audio);
        model_step(r, e, l);
        #1;
        model_check();
    endtask

    typedef struct {
        bit r; bit e; bit l; int n;
        int st; int areset; int retry; int loss;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int hold;
        bit lk_r;
        bit hit;

        // rst en lk n | state areset retry loss
        tbl.push_back('{1, 0, 0, 1, P_IDLE,   1, 0, 0});  // reset values
        tbl.push_back('{0, 1, 0, 1, P_RESET,  1, 0, 0});  // enable -> RESET
        tbl.push_back('{0, 1, 0, 4, P_WAIT,   0, 0, 0});  // 4-cycle PLL reset
        tbl.push_back('{0, 1, 0, 2, P_WAIT,   0, 0, 0});  // lock arrives 2 cycles after areset falls
        tbl.push_back('{0, 1, 1, 2, P_WAIT,   0, 0, 0});  // synchroniser delay
        tbl.push_back('{0, 1, 1, 1, P_SETTLE, 0, 0, 0});  // 3rd edge after rise
        tbl.push_back('{0, 1, 1, 7, P_SETTLE, 0, 0, 0});
        tbl.push_back('{0, 1, 1, 1, P_RUN,    0, 0, 0});  // edge 18 = 1+4+3+8 +2 late lock
        tbl.push_back('{0, 1, 0, 2, P_RUN,    0, 0, 0});  // lock drop in flight
        tbl.push_back('{0, 1, 0, 1, P_RESET,  1, 0, 1});  // loss -> RESET, loss_cnt=1
        tbl.push_back('{0, 1, 1, 4, P_WAIT,   0, 0, 1});
        tbl.push_back('{0, 1, 1, 1, P_SETTLE, 0, 0, 1});
        tbl.push_back('{0, 1, 0, 1, P_SETTLE, 0, 0, 1});  // 1-cycle glitch
        tbl.push_back('{0, 1, 1, 1, P_SETTLE, 0, 0, 1});
        tbl.push_back('{0, 1, 1, 1, P_RESET,  1, 1, 1});  // glitch fails attempt
        tbl.push_back('{0, 1, 1, 4, P_WAIT,   0, 1, 1});
        tbl.push_back('{0, 1, 1, 1, P_SETTLE, 0, 1, 1});
        tbl.push_back('{0, 1, 1, 8, P_RUN,    0, 0, 1});  // RUN clears retry_cnt
        tbl.push_back('{0, 1, 0, 3, P_RESET,  1, 0, 2});
        tbl.push_back('{0, 1, 1, 4, P_WAIT,   0, 0, 2});
        tbl.push_back('{0, 1, 1, 1, P_SETTLE, 0, 0, 2});
        tbl.push_back('{0, 1, 1, 3, P_SETTLE, 0, 0, 2});
        tbl.push_back('{0, 0, 1, 1, P_IDLE,   1, 0, 2});  // enable drop mid-SETTLE keeps loss_cnt
        tbl.push_back('{0, 1, 0, 5, P_WAIT,   0, 0, 2});
        tbl.push_back('{0, 1, 0, 3, P_WAIT,   0, 0, 2});
        tbl.push_back('{1, 1, 0, 1, P_IDLE,   1, 0, 0});  // reset mid-WAIT_LOCK

        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].n; k++) step(tbl[i].r, tbl[i].e, tbl[i].l);
            chk($sformatf("vec%0d_state", i), int'(state), tbl[i].st);
            chk($sformatf("vec%0d_areset", i), int'(pll_areset), tbl[i].areset);
            chk($sformatf("vec%0d_retry", i), int'(retry_cnt), tbl[i].retry);
            chk($sformatf("vec%0d_loss", i), int'(loss_cnt), tbl[i].loss);
        end

        // Lock never arrives: four 4-cycle resets each followed by a 20-cycle wait, then FAULT.
        for (int a = 0; a <= MAXR; a++) begin
            for (int c = 0; c < RST_C; c++) begin
                step(0, 1, 0);
                chk("nolock_reset_state", int'(state), P_RESET);
                chk("nolock_retry", int'(retry_cnt), a);
            end
            for (int c = 0; c < TIMEOUT; c++) begin
                step(0, 1, 0);
                chk("nolock_wait_state", int'(state), P_WAIT);
                chk("nolock_wait_areset", int'(pll_areset), 0);
            end
        end
        for (int c = 0; c < 5; c++) begin
            step(0, 1, 1);
            chk("fault_state", int'(state), P_FAULT);
            chk("fault_flag", int'(fault), 1);
            chk("fault_areset", int'(pll_areset), 1);
        end
        step(0, 0, 1);
        chk("fault_exit_state", int'(state), P_IDLE);
        chk("fault_exit_flag", int'(fault), 0);

        // Repeated lock loss saturates loss_cnt.
        step(1, 0, 1);
        for (int i = 0; i < 300; i++) begin
            hit = 1'b0;
            for (int c = 0; c < 60 && !hit; c++) begin
                step(0, 1, 1);
                hit = (state == 3'(P_RUN));
            end
            chk("loss_reach_run", int'(hit), 1);
            hit = 1'b0;
            for (int c = 0; c < 10 && !hit; c++) begin
                step(0, 1, 0);
                hit = (state == 3'(P_RESET));
            end
            chk("loss_reach_reset", int'(hit), 1);
            if (i == 0) begin
                chk("loss_first", int'(loss_cnt), 1);
                chk("loss_first_rst_n", int'(audio_rst_n), 0);
                chk("loss_first_ready", int'(ready), 0);
            end
        end
        chk("loss_saturated", int'(loss_cnt), 255);

        // Randomized run against the model.
        hold = 0;
        lk_r = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (hold == 0) begin
                lk_r = 1'($urandom_range(0, 1));
                hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 120))
                                                   : int'($urandom_range(1, 12));
            end
            hold--;
            step(($urandom_range(0, 499) == 0), ($urandom_range(0, 99) < 97), lk_r);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
